// File: rtl/dmem_dump_reader_if.sv
// Readback stream carrying one data-memory word together with its address.
// The dump engine drives the master side; a debug UART or bench scoreboard
// consumes the slave side.
interface dmem_dump_reader_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_addr;
  logic          dump_valid;
  logic          dump_ready;

  modport master (
    output dump_data,
    output dump_addr,
    output dump_valid,
    input  dump_ready
  );

  modport slave (
    input  dump_data,
    input  dump_addr,
    input  dump_valid,
    output dump_ready
  );
endinterface

// File: rtl/dmem_dump_reader.sv
// Post-run data-memory readback engine for the 16-bit single-cycle CPU.
// After HLT rises (with auto_en) or on a manual start pulse, it walks
// test_addr across [base_addr, base_addr+count) with wraparound, samples
// D_memory_out, and streams each word with its address on a valid/ready port.
// dump_sel tells the external mux that this block currently owns test_addr.
module dmem_dump_reader #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic                CLK,
  input  logic                clr_n,
  input  logic                HLT,
  input  logic                start,
  input  logic                auto_en,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW:0]         count,
  output logic [AW-1:0]       test_addr,
  output logic                dump_sel,
  input  logic [DW-1:0]       D_memory_out,
  dmem_dump_reader_if.master  dump,
  output logic                dump_busy,
  output logic                dump_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPT,
    S_PRES
  } state_t;

  state_t        state;
  logic          hlt_q;
  logic          hlt_rise;
  logic          trigger;
  logic [AW-1:0] ptr;
  logic [AW:0]   remaining;

  // A simultaneous start and HLT edge collapse into a single trigger.
  assign hlt_rise = HLT & ~hlt_q;
  assign trigger  = start | (auto_en & hlt_rise);

  // Sweep controller: all outputs are registered here so the test-port mux
  // and the stream see glitch-free signals.
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      state           <= S_IDLE;
      hlt_q           <= 1'b0;
      ptr             <= '0;
      remaining       <= '0;
      test_addr       <= '0;
      dump_sel        <= 1'b0;
      dump_busy       <= 1'b0;
      dump_done       <= 1'b0;
      dump.dump_data  <= '0;
      dump.dump_addr  <= '0;
      dump.dump_valid <= 1'b0;
    end else begin
      hlt_q     <= HLT;
      dump_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // base/count are captured only here; later changes cannot disturb
          // a sweep in progress.
          if (trigger) begin
            ptr       <= base_addr;
            remaining <= count;
            if (count == '0) begin
              dump_done <= 1'b1;
            end else begin
              test_addr <= base_addr;
              dump_sel  <= 1'b1;
              dump_busy <= 1'b1;
              state     <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          state <= (RD_LAT == 0) ? S_CAPT : S_WAIT;
        end
        S_WAIT: begin
          state <= S_CAPT;
        end
        S_CAPT: begin
          dump.dump_data  <= D_memory_out;
          dump.dump_addr  <= ptr;
          dump.dump_valid <= 1'b1;
          state           <= S_PRES;
        end
        S_PRES: begin
          // Word and address stay frozen until the consumer takes them.
          if (dump.dump_ready) begin
            dump.dump_valid <= 1'b0;
            remaining       <= remaining - 1'b1;
            ptr             <= ptr + 1'b1;
            if (remaining == (AW+1)'(1)) begin
              // test_addr keeps the last swept address while idle.
              dump_sel  <= 1'b0;
              dump_busy <= 1'b0;
              dump_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              test_addr <= ptr + 1'b1;
              state     <= S_ADDR;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Bench for dmem_dump_reader: a synchronous data memory with a bench-owned
// address/write path muxed by dump_sel, directed scenarios in the main
// process, and a monitor that pops an expected-beat queue on each transfer.
module tb_dmem_dump_reader;
  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic          CLK = 1'b0;
  logic          clr_n = 1'b0;
  logic          HLT = 1'b0;
  logic          start = 1'b0;
  logic          auto_en = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] test_addr;
  logic          dump_sel;
  logic [DW-1:0] D_memory_out;
  logic          dump_busy;
  logic          dump_done;

  dmem_dump_reader_if #(.AW(AW), .DW(DW)) dif ();

  dmem_dump_reader #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .CLK          (CLK),
    .clr_n        (clr_n),
    .HLT          (HLT),
    .start        (start),
    .auto_en      (auto_en),
    .base_addr    (base_addr),
    .count        (count),
    .test_addr    (test_addr),
    .dump_sel     (dump_sel),
    .D_memory_out (D_memory_out),
    .dump         (dif),
    .dump_busy    (dump_busy),
    .dump_done    (dump_done)
  );

  always #5 CLK = ~CLK;

  // Data memory: one-cycle registered read, bench-side write port.
  logic [DW-1:0] mem [256];
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_waddr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [AW-1:0] bench_addr = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_q;

  assign rd_addr      = dump_sel ? test_addr : bench_addr;
  assign D_memory_out = rd_q;

  always @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_q <= mem[rd_addr];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  beat_t exp_q[$];
  int    rise_q[$];
  int    errors = 0;
  int    checks = 0;
  int    beats = 0;
  int    dones = 0;
  int    cyc = 0;
  int    rst_gen = 0;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge clr_n) rst_gen <= rst_gen + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each transfer against the queue head, checks that a
  // stalled beat stays frozen, and counts done pulses.
  initial begin : monitor
    beat_t         e;
    logic          hold;
    logic          pv;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    int            seen_rst;
    hold = 1'b0;
    pv = 1'b0;
    ha = '0;
    hd = '0;
    seen_rst = 0;
    forever begin
      @(negedge CLK);
      if (rst_gen != seen_rst) begin
        hold = 1'b0;
        seen_rst = rst_gen;
      end
      if (hold) begin
        check("stall_valid", {31'b0, dif.dump_valid}, 32'd1);
        check("stall_data", {16'b0, dif.dump_data}, {16'b0, hd});
        check("stall_addr", {24'b0, dif.dump_addr}, {24'b0, ha});
      end
      if (dif.dump_valid && !pv) rise_q.push_back(cyc);
      pv = dif.dump_valid;
      if (dif.dump_valid && dif.dump_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat_addr", {24'b0, dif.dump_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", {24'b0, dif.dump_addr}, {24'b0, e.a});
          check("beat_data", {16'b0, dif.dump_data}, {16'b0, e.d});
        end
        hold = 1'b0;
      end else if (dif.dump_valid) begin
        hold = 1'b1;
        ha = dif.dump_addr;
        hd = dif.dump_data;
      end else begin
        hold = 1'b0;
      end
      if (dump_done) dones++;
      if (dump_sel) check("mem_write_while_sel", {31'b0, mem_we}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_waddr = a;
    mem_wdata = d;
    mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    beat_t b;
    b.a = a;
    b.d = d;
    exp_q.push_back(b);
  endtask

  task automatic wait_done(input int d0, input int bound, input string name);
    int n;
    n = 0;
    while (dones == d0 && n < bound) begin
      tick();
      n++;
    end
    check(name, dones - d0, 32'd1);
  endtask

  task automatic wait_valid(input int bound, input string name);
    int n;
    n = 0;
    while (!dif.dump_valid && n < bound) begin
      tick();
      n++;
    end
    check(name, {31'b0, dif.dump_valid}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_test_addr"}, {24'b0, test_addr}, 32'd0);
    check({tag, "_sel"}, {31'b0, dump_sel}, 32'd0);
    check({tag, "_valid"}, {31'b0, dif.dump_valid}, 32'd0);
    check({tag, "_busy"}, {31'b0, dump_busy}, 32'd0);
    check({tag, "_done"}, {31'b0, dump_done}, 32'd0);
    check({tag, "_data"}, {16'b0, dif.dump_data}, 32'd0);
    check({tag, "_addr"}, {24'b0, dif.dump_addr}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0;
    int b0;
    int n0;
    int trig;
    logic [DW-1:0] src [5];
    src[0] = 16'h1111; src[1] = 16'h2222; src[2] = 16'h3333;
    src[3] = 16'h4444; src[4] = 16'h5555;
    dif.dump_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    clr_n = 1'b1;
    tick();

    // Basic readback with HLT auto-trigger
    mem_write(8'h25, 16'h0041);
    mem_write(8'h26, 16'h0009);
    base_addr = 8'h25;
    count = 9'd2;
    auto_en = 1'b1;
    dif.dump_ready = 1'b1;
    push_exp(8'h25, 16'h0041);
    push_exp(8'h26, 16'h0009);
    d0 = dones;
    b0 = beats;
    n0 = rise_q.size();
    HLT = 1'b1;
    trig = cyc + 1;
    wait_done(d0, 60, "basic_done");
    check("basic_beats", beats - b0, 32'd2);
    if (rise_q.size() > n0) check("basic_first_valid_latency", rise_q[n0] - trig, 32'd3);
    else check("basic_first_valid_seen", rise_q.size(), n0 + 1);
    repeat (4) tick();
    check("basic_single_done", dones - d0, 32'd1);
    check("basic_sel_released", {31'b0, dump_sel}, 32'd0);
    check("basic_busy_released", {31'b0, dump_busy}, 32'd0);

    // Backpressure: five stalled cycles on the first beat
    dif.dump_ready = 1'b0;
    push_exp(8'h25, 16'h0041);
    push_exp(8'h26, 16'h0009);
    d0 = dones;
    b0 = beats;
    pulse_start();
    wait_valid(20, "bp_valid");
    repeat (5) tick();
    dif.dump_ready = 1'b1;
    wait_done(d0, 60, "bp_done");
    check("bp_beats", beats - b0, 32'd2);

    // Address wrap 0xFE -> 0xFF -> 0x00
    mem_write(8'hFE, 16'hA1B2);
    mem_write(8'hFF, 16'hC3D4);
    mem_write(8'h00, 16'h1357);
    base_addr = 8'hFE;
    count = 9'd3;
    push_exp(8'hFE, 16'hA1B2);
    push_exp(8'hFF, 16'hC3D4);
    push_exp(8'h00, 16'h1357);
    d0 = dones;
    b0 = beats;
    pulse_start();
    wait_done(d0, 60, "wrap_done");
    check("wrap_beats", beats - b0, 32'd3);

    // count = 0: done the cycle after start, nothing else moves
    count = 9'd0;
    d0 = dones;
    b0 = beats;
    pulse_start();
    check("cnt0_done_pulse", {31'b0, dump_done}, 32'd1);
    check("cnt0_sel", {31'b0, dump_sel}, 32'd0);
    check("cnt0_valid", {31'b0, dif.dump_valid}, 32'd0);
    check("cnt0_busy", {31'b0, dump_busy}, 32'd0);
    tick();
    check("cnt0_done_drop", {31'b0, dump_done}, 32'd0);
    check("cnt0_done_count", dones - d0, 32'd1);
    check("cnt0_beats", beats - b0, 32'd0);

    // Block move: source 0x00-0x04, copied to 0x0A-0x0E through memory
    for (int i = 0; i < 5; i++) mem_write(AW'(i), src[i]);
    for (int i = 0; i < 5; i++) begin
      bench_addr = AW'(i);
      tick();
      mem_write(AW'(8'h0A + i), rd_q);
    end
    HLT = 1'b0;
    tick();
    base_addr = 8'h0A;
    count = 9'd5;
    auto_en = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(AW'(8'h0A + i), src[i]);
    d0 = dones;
    b0 = beats;
    HLT = 1'b1;
    wait_done(d0, 100, "bm_done");
    check("bm_beats", beats - b0, 32'd5);

    // Triggers and input changes while busy are ignored
    mem_write(8'h10, 16'h00AA);
    mem_write(8'h11, 16'h00BB);
    mem_write(8'h12, 16'h00CC);
    HLT = 1'b0;
    tick();
    base_addr = 8'h10;
    count = 9'd3;
    push_exp(8'h10, 16'h00AA);
    push_exp(8'h11, 16'h00BB);
    push_exp(8'h12, 16'h00CC);
    d0 = dones;
    b0 = beats;
    pulse_start();
    base_addr = 8'h55;
    count = 9'd7;
    tick();
    pulse_start();
    tick();
    HLT = 1'b1;
    wait_done(d0, 80, "busy_trig_done");
    check("busy_trig_beats", beats - b0, 32'd3);
    repeat (10) tick();
    check("busy_trig_no_restart", {31'b0, dump_busy}, 32'd0);
    check("busy_trig_single_done", dones - d0, 32'd1);

    // auto_en = 0: HLT rising does nothing
    HLT = 1'b0;
    tick();
    auto_en = 1'b0;
    d0 = dones;
    b0 = beats;
    HLT = 1'b1;
    repeat (20) tick();
    check("noauto_beats", beats - b0, 32'd0);
    check("noauto_done", dones - d0, 32'd0);
    check("noauto_sel", {31'b0, dump_sel}, 32'd0);

    // Reset while the second beat is presented
    mem_write(8'h30, 16'h0300);
    mem_write(8'h31, 16'h0301);
    mem_write(8'h32, 16'h0302);
    base_addr = 8'h30;
    count = 9'd3;
    dif.dump_ready = 1'b0;
    push_exp(8'h30, 16'h0300);
    b0 = beats;
    pulse_start();
    wait_valid(20, "rst_first_valid");
    dif.dump_ready = 1'b1;
    tick();
    dif.dump_ready = 1'b0;
    wait_valid(20, "rst_second_valid");
    d0 = dones;
    #1;
    clr_n = 1'b0;
    #1;
    check_all_zero("midreset");
    #1;
    clr_n = 1'b1;
    tick();
    check("midreset_no_done", dones - d0, 32'd0);
    check("midreset_beats", beats - b0, 32'd1);
    mem_write(8'h40, 16'h4000);
    mem_write(8'h41, 16'h4001);
    base_addr = 8'h40;
    count = 9'd2;
    dif.dump_ready = 1'b1;
    push_exp(8'h40, 16'h4000);
    push_exp(8'h41, 16'h4001);
    d0 = dones;
    b0 = beats;
    pulse_start();
    wait_done(d0, 60, "restart_done");
    check("restart_beats", beats - b0, 32'd2);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
